// File: rtl/ov7670_capture_pkg.sv
// Shared types and constants for the OV7670 frame capture block: the FSM state
// enum, the camera input format encodings and the legal stored pixel widths.
package ov7670_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_CAPTURE,
    ST_DONE
  } cap_state_t;

  localparam logic FMT_RGB565 = 1'b0;
  localparam logic FMT_RGB444 = 1'b1;

  localparam int PIX_W_RGB332 = 8;
  localparam int PIX_W_RGB444 = 12;
  localparam int PIX_W_RGB565 = 16;

  function automatic bit pix_w_legal(input int w);
    return (w == PIX_W_RGB332) || (w == PIX_W_RGB444) || (w == PIX_W_RGB565);
  endfunction

endpackage

// File: rtl/ov7670_frame_capture_if.sv
// Bundle of the camera byte stream and the frame RAM write port, used by
// whatever sits on either side of ov7670_frame_capture.
interface ov7670_frame_capture_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 15
);
  logic              vsync;
  logic              href;
  logic [7:0]        data;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_en;

  modport master (output vsync, href, data, input wr_addr, wr_data, wr_en);
  modport slave  (input vsync, href, data, output wr_addr, wr_data, wr_en);
endinterface

// File: rtl/ov7670_px_pack.sv
// Combinational pixel converter: two camera bytes (RGB565 or RGB444) are
// expanded to 5/6/5 and then truncated to the stored PIX_W format.
module ov7670_px_pack
  import ov7670_capture_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [7:0]       hi_byte,
  input  logic [7:0]       lo_byte,
  input  logic             in_fmt,
  output logic [PIX_W-1:0] pixel
);

  logic [4:0] r5;
  logic [5:0] g6;
  logic [4:0] b5;

  // RGB444 channels are widened by replicating their top bits
  always_comb begin
    if (in_fmt == FMT_RGB444) begin
      r5 = {hi_byte[3:0], hi_byte[3]};
      g6 = {lo_byte[7:4], lo_byte[7:6]};
      b5 = {lo_byte[3:0], lo_byte[3]};
    end else begin
      r5 = hi_byte[7:3];
      g6 = {hi_byte[2:0], lo_byte[7:5]};
      b5 = lo_byte[4:0];
    end
  end

  generate
    if (PIX_W == PIX_W_RGB565) begin : gen_565
      assign pixel = PIX_W'({r5, g6, b5});
    end else if (PIX_W == PIX_W_RGB444) begin : gen_444
      logic unused_lsbs;
      assign unused_lsbs = ^{r5[0], g6[1:0], b5[0]};
      assign pixel = PIX_W'({r5[4:1], g6[5:2], b5[4:1]});
    end else begin : gen_332
      logic unused_lsbs;
      assign unused_lsbs = ^{r5[1:0], g6[2:0], b5[2:0]};
      assign pixel = PIX_W'({r5[4:2], g6[5:3], b5[4:3]});
    end
  endgenerate

endmodule

// File: rtl/ov7670_frame_capture.sv
// OV7670 frame grabber: arms on start, captures one frame per Vsync period into
// a pixel RAM. Optional 2x2 decimation is built only with OV7670_CAPTURE_DECIM_EN.
module ov7670_frame_capture
  import ov7670_capture_pkg::*;
#(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 15
) (
  input  logic              Pclk,
  input  logic              RESET,
  input  logic              Vsync,
  input  logic              Href,
  input  logic [7:0]        Datos,
  input  logic              start,
  input  logic              single,
  input  logic              in_fmt,
  input  logic              decim,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  datos,
  output logic              Write,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              line_err,
  output logic [7:0]        frame_cnt
);

  localparam int CNT_W = 16;
  localparam logic [ADDR_W:0]  DEPTH_FULL = (ADDR_W+1)'(H_RES * V_RES);
  localparam logic [CNT_W-1:0] LINE_FULL  = CNT_W'(H_RES);

  cap_state_t        state;
  logic              vsync_q, href_q, phase, end_pend;
  logic [7:0]        hi_byte;
  logic [ADDR_W:0]   px_idx;
  logic [CNT_W-1:0]  col;
  logic [PIX_W-1:0]  pixel;

  logic              vs_fall, vs_rise, href_fall, low_byte;
  logic              cap_start, frame_end_now, line_end;
  logic              keep;
  logic [ADDR_W:0]   depth;
  logic [CNT_W-1:0]  line_cnt, line_exp;

  assign vs_fall   = vsync_q & ~Vsync;
  assign vs_rise   = ~vsync_q & Vsync;
  assign href_fall = href_q & ~Href;
  assign low_byte  = Href & phase;
  assign cap_start = (state == ST_WAIT_VS) && vs_fall;
  // A frame end that lands on a low byte is deferred one cycle so the pixel goes out first
  assign frame_end_now = (state == ST_CAPTURE) && (end_pend || (vs_rise && !low_byte));
  assign line_end  = (state == ST_CAPTURE) && !frame_end_now && href_fall;

  ov7670_px_pack #(.PIX_W(PIX_W)) u_px_pack (
    .hi_byte (hi_byte),
    .lo_byte (Datos),
    .in_fmt  (in_fmt),
    .pixel   (pixel)
  );

`ifdef OV7670_CAPTURE_DECIM_EN
  localparam logic [ADDR_W:0]  DEPTH_DEC = (ADDR_W+1)'((H_RES / 2) * (V_RES / 2));
  localparam logic [CNT_W-1:0] LINE_DEC  = CNT_W'(H_RES / 2);

  logic decim_q, row_odd;

  // Decimated lines are judged on how many even-column pixels they carried
  assign keep     = ~decim_q | (~col[0] & ~row_odd);
  assign depth    = decim_q ? DEPTH_DEC : DEPTH_FULL;
  assign line_cnt = decim_q ? ((col >> 1) + {{(CNT_W-1){1'b0}}, col[0]}) : col;
  assign line_exp = decim_q ? LINE_DEC : LINE_FULL;

  always_ff @(posedge Pclk) begin
    if (RESET) begin
      decim_q <= 1'b0;
      row_odd <= 1'b0;
    end else if (cap_start) begin
      decim_q <= decim;
      row_odd <= 1'b0;
    end else if (line_end) begin
      row_odd <= ~row_odd;
    end
  end
`else
  logic unused_decim;

  assign unused_decim = decim;
  assign keep     = 1'b1;
  assign depth    = DEPTH_FULL;
  assign line_cnt = col;
  assign line_exp = LINE_FULL;
`endif

  always_ff @(posedge Pclk) begin
    if (RESET) begin
      state      <= ST_IDLE;
      addr       <= '0;
      datos      <= '0;
      Write      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      line_err   <= 1'b0;
      frame_cnt  <= 8'd0;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      phase      <= 1'b0;
      end_pend   <= 1'b0;
      hi_byte    <= 8'd0;
      px_idx     <= '0;
      col        <= '0;
    end else begin
      vsync_q    <= Vsync;
      href_q     <= Href;
      Write      <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_WAIT_VS;
            busy     <= 1'b1;
            overflow <= 1'b0;
            line_err <= 1'b0;
          end
        end
        ST_WAIT_VS: begin
          if (vs_fall) begin
            state    <= ST_CAPTURE;
            addr     <= '0;
            px_idx   <= '0;
            phase    <= 1'b0;
            col      <= '0;
            end_pend <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (frame_end_now) begin
            end_pend   <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            if (single) begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end else begin
              state <= ST_WAIT_VS;
            end
          end else begin
            if (vs_rise) end_pend <= 1'b1;
            if (Href) begin
              phase <= ~phase;
              if (!phase) begin
                hi_byte <= Datos;
              end else begin
                col <= col + 1'b1;
                // Past the frame depth the pixel is dropped and addr parks on the last slot
                if (keep) begin
                  if (px_idx < depth) begin
                    Write  <= 1'b1;
                    addr   <= px_idx[ADDR_W-1:0];
                    datos  <= pixel;
                    px_idx <= px_idx + 1'b1;
                  end else begin
                    overflow <= 1'b1;
                    addr     <= ADDR_W'(depth - 1'b1);
                  end
                end
              end
            end else if (line_end) begin
              phase <= 1'b0;
              col   <= '0;
              if (line_cnt != line_exp) line_err <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
